// File: rtl/afifo_rd_control.sv
// Read-side pointer controller for the asynchronous FIFO: read pointer, 2-flop write-pointer sync, empty/underflow.
// Define AFIFO_RD_LEVEL_EN to add the registered RDlevel and FIFOalmostEmpty outputs.
module afifo_rd_control #(
  parameter int AddrLines      = 3,
  parameter int AlmostEmptyThr = 1
) (
  input  logic                 RDclk,
  input  logic                 reset,
  input  logic                 RDreq,
  input  logic [AddrLines:0]   GrayWRaddr,
  output logic                 RDen,
  output logic [AddrLines-1:0] RDaddr,
  output logic [AddrLines:0]   GrayRDaddr,
  output logic                 FIFOempty,
  output logic                 RDerr
`ifdef AFIFO_RD_LEVEL_EN
  ,
  output logic [AddrLines:0]   RDlevel,
  output logic                 FIFOalmostEmpty
`endif
);

  logic [AddrLines:0] r_gray_wr_sync1;
  logic [AddrLines:0] r_gray_wr_sync2;
  logic [AddrLines:0] r_bin_rd;
  logic [AddrLines:0] r_gray_rd;
  logic               r_rd_err;
  logic [AddrLines:0] w_bin_rd_next;
  logic [AddrLines:0] w_gray_rd_next;
  logic               w_empty;
  logic               w_rd_en;

  always_ff @(posedge RDclk or negedge reset) begin
    if (!reset) begin
      r_gray_wr_sync1 <= '0;
      r_gray_wr_sync2 <= '0;
    end else begin
      r_gray_wr_sync1 <= GrayWRaddr;
      r_gray_wr_sync2 <= r_gray_wr_sync1;
    end
  end

  // Extra pointer MSB makes equal Gray pointers mean empty, never full.
  assign w_empty        = (r_gray_rd == r_gray_wr_sync2);
  assign w_rd_en        = RDreq & ~w_empty;
  assign w_bin_rd_next  = r_bin_rd + {{AddrLines{1'b0}}, w_rd_en};
  assign w_gray_rd_next = w_bin_rd_next ^ (w_bin_rd_next >> 1);

  always_ff @(posedge RDclk or negedge reset) begin
    if (!reset) begin
      r_bin_rd  <= '0;
      r_gray_rd <= '0;
      r_rd_err  <= 1'b0;
    end else begin
      r_bin_rd  <= w_bin_rd_next;
      r_gray_rd <= w_gray_rd_next;
      if (RDreq && w_empty) r_rd_err <= 1'b1;
    end
  end

  assign RDen       = w_rd_en;
  assign RDaddr     = r_bin_rd[AddrLines-1:0];
  assign GrayRDaddr = r_gray_rd;
  assign FIFOempty  = w_empty;
  assign RDerr      = r_rd_err;

`ifdef AFIFO_RD_LEVEL_EN
  localparam logic [AddrLines:0] THR = (AddrLines+1)'(AlmostEmptyThr);

  logic [AddrLines:0] w_bin_wr_sync;
  logic [AddrLines:0] w_level_next;
  logic [AddrLines:0] r_level;
  logic               r_almost_empty;

  always_comb begin
    w_bin_wr_sync            = '0;
    w_bin_wr_sync[AddrLines] = r_gray_wr_sync2[AddrLines];
    for (int i = AddrLines - 1; i >= 0; i--) begin
      w_bin_wr_sync[i] = w_bin_wr_sync[i+1] ^ r_gray_wr_sync2[i];
    end
  end

  assign w_level_next = w_bin_wr_sync - w_bin_rd_next;

  always_ff @(posedge RDclk or negedge reset) begin
    if (!reset) begin
      r_level        <= '0;
      r_almost_empty <= 1'b1;
    end else begin
      r_level        <= w_level_next;
      r_almost_empty <= (w_level_next <= THR);
    end
  end

  assign RDlevel         = r_level;
  assign FIFOalmostEmpty = r_almost_empty;
`endif

endmodule

// File: tb/tb_afifo_rd_control.sv
// Self-checking bench for afifo_rd_control: randomized writes/reads against a counter-based occupancy model.
// Level outputs are checked only when AFIFO_RD_LEVEL_EN is defined.
module tb_afifo_rd_control;
  localparam int AW  = 3;
  localparam int MOD = 16;
  localparam int THR = 1;

  logic          RDclk = 1'b0;
  logic          reset;
  logic          RDreq;
  logic [AW:0]   GrayWRaddr;
  logic          RDen;
  logic [AW-1:0] RDaddr;
  logic [AW:0]   GrayRDaddr;
  logic          FIFOempty;
  logic          RDerr;
`ifdef AFIFO_RD_LEVEL_EN
  logic [AW:0]   RDlevel;
  logic          FIFOalmostEmpty;
`endif

  afifo_rd_control #(.AddrLines(AW), .AlmostEmptyThr(THR)) dut (
    .RDclk(RDclk), .reset(reset), .RDreq(RDreq), .GrayWRaddr(GrayWRaddr),
    .RDen(RDen), .RDaddr(RDaddr), .GrayRDaddr(GrayRDaddr),
    .FIFOempty(FIFOempty), .RDerr(RDerr)
`ifdef AFIFO_RD_LEVEL_EN
    , .RDlevel(RDlevel), .FIFOalmostEmpty(FIFOalmostEmpty)
`endif
  );

  always #5 RDclk = ~RDclk;

  // Reference model: writes and reads as counts modulo 2*depth; the write count
  // becomes visible to the read side two edges after it is driven.
  int  wr_cnt;
  int  rd_cnt;
  int  vis1, vis2;
  bit  m_err;
  int  m_lvl;
  bit  m_ae;
  int  vectors;
  int  miscompares;

  logic [AW:0] wr_bin;
  assign wr_bin     = (AW+1)'(wr_cnt);
  assign GrayWRaddr = wr_bin ^ (wr_bin >> 1);

  function automatic logic [AW:0] to_gray(int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic step();
    bit emp;
    int rd_new;
    emp = (rd_cnt == vis2);
    @(posedge RDclk);
    rd_new = (rd_cnt + ((RDreq && !emp) ? 1 : 0)) % MOD;
    if (RDreq && emp) m_err = 1'b1;
    m_lvl  = (vis2 - rd_new + MOD) % MOD;
    m_ae   = (m_lvl <= THR);
    vis2   = vis1;
    vis1   = wr_cnt;
    rd_cnt = rd_new;
    #1;
  endtask

  task automatic model_reset();
    wr_cnt = 0; rd_cnt = 0; vis1 = 0; vis2 = 0;
    m_err = 1'b0; m_lvl = 0; m_ae = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    RDreq = 1'b0;
    model_reset();
    @(negedge RDclk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (((wr_cnt - rd_cnt + MOD) % MOD) < 8) wr_cnt = (wr_cnt + 1) % MOD;
      RDreq = (i > 4);
      #1;
      step();
    end
    #2;
    reset = 1'b0;
    RDreq = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (FIFOempty !== 1'b1 || RDen !== 1'b0 || RDaddr !== '0 || GrayRDaddr !== '0 || RDerr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: empty=%b rden=%b rdaddr=%0d gray=%b err=%b, required empty=1 rden=0 rdaddr=0 gray=0000 err=0",
               FIFOempty, RDen, RDaddr, GrayRDaddr, RDerr);
    end
`ifdef AFIFO_RD_LEVEL_EN
    vectors++;
    if (RDlevel !== '0 || FIFOalmostEmpty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_level: level=%0d ae=%b, required level=0 ae=1", RDlevel, FIFOalmostEmpty);
    end
`endif
    RDreq = 1'b0;
    @(negedge RDclk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_sync_latency();
    do_reset();
    wr_cnt = 1;
    for (int e = 1; e <= 3; e++) begin
      step();
      vectors++;
      if (FIFOempty !== ((e < 2) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL sync_empty edge%0d: got %b required %b", e, FIFOempty, (e < 2) ? 1'b1 : 1'b0);
      end
`ifdef AFIFO_RD_LEVEL_EN
      vectors++;
      if (RDlevel !== ((e < 3) ? 4'd0 : 4'd1) || FIFOalmostEmpty !== 1'b1) begin
        miscompares++;
        $display("FAIL sync_level edge%0d: level=%0d ae=%b required level=%0d ae=1",
                 e, RDlevel, FIFOalmostEmpty, (e < 3) ? 0 : 1);
      end
`endif
    end
  endtask

  task automatic test_burst_drain();
    do_reset();
    wr_cnt = 8;
    repeat (3) step();
`ifdef AFIFO_RD_LEVEL_EN
    vectors++;
    if (RDlevel !== 4'd8 || FIFOalmostEmpty !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_full_level: level=%0d ae=%b required level=8 ae=0", RDlevel, FIFOalmostEmpty);
    end
`endif
    RDreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (RDen !== 1'b1 || RDaddr !== AW'(i) || FIFOempty !== 1'b0) begin
        miscompares++;
        $display("FAIL burst_read%0d: rden=%b rdaddr=%0d empty=%b required rden=1 rdaddr=%0d empty=0",
                 i, RDen, RDaddr, FIFOempty, i);
      end
      step();
    end
    vectors++;
    if (FIFOempty !== 1'b1 || RDen !== 1'b0 || GrayRDaddr !== 4'b1100 || RDerr !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_end: empty=%b rden=%b gray=%b err=%b required empty=1 rden=0 gray=1100 err=0",
               FIFOempty, RDen, GrayRDaddr, RDerr);
    end
`ifdef AFIFO_RD_LEVEL_EN
    vectors++;
    if (RDlevel !== 4'd0 || FIFOalmostEmpty !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_end_level: level=%0d ae=%b required level=0 ae=1", RDlevel, FIFOalmostEmpty);
    end
`endif
    RDreq = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    repeat (2) step();
    RDreq = 1'b1;
    #1;
    vectors++;
    if (RDen !== 1'b0 || FIFOempty !== 1'b1 || RDerr !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_pre: rden=%b empty=%b err=%b required rden=0 empty=1 err=0", RDen, FIFOempty, RDerr);
    end
    step();
    RDreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (RDerr !== 1'b1 || RDaddr !== '0 || GrayRDaddr !== '0) begin
        miscompares++;
        $display("FAIL underflow_hold%0d: err=%b rdaddr=%0d gray=%b required err=1 rdaddr=0 gray=0000",
                 i, RDerr, RDaddr, GrayRDaddr);
      end
      if (i == 1) wr_cnt = 2;
      step();
    end
    do_reset();
    vectors++;
    if (RDerr !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: err=%b required 0", RDerr);
    end
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      wr_cnt = (wr_cnt + 8) % MOD;
      RDreq  = 1'b1;
      budget = 0;
      do begin
        #1;
        vectors++;
        if (FIFOempty !== (rd_cnt == vis2) || RDen !== (rd_cnt != vis2) ||
            RDaddr !== AW'(rd_cnt % 8) || GrayRDaddr !== to_gray(rd_cnt) || RDerr !== m_err) begin
          miscompares++;
          $display("FAIL wrap c%0d: empty=%b rden=%b rdaddr=%0d gray=%b err=%b required empty=%b rden=%b rdaddr=%0d gray=%b err=%b",
                   c, FIFOempty, RDen, RDaddr, GrayRDaddr, RDerr, rd_cnt == vis2, rd_cnt != vis2,
                   rd_cnt % 8, to_gray(rd_cnt), m_err);
        end
`ifdef AFIFO_RD_LEVEL_EN
        vectors++;
        if (RDlevel !== (AW+1)'(m_lvl) || FIFOalmostEmpty !== m_ae) begin
          miscompares++;
          $display("FAIL wrap_level c%0d: level=%0d ae=%b required level=%0d ae=%b", c, RDlevel, FIFOalmostEmpty, m_lvl, m_ae);
        end
`endif
        step();
        budget++;
      end while (!(rd_cnt == wr_cnt && vis1 == wr_cnt && vis2 == wr_cnt) && budget < 40);
      vectors++;
      if (budget >= 40) begin
        miscompares++;
        $display("FAIL wrap_timeout c%0d: rd=%0d required %0d", c, rd_cnt, wr_cnt);
      end
    end
    RDreq = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (((wr_cnt - rd_cnt + MOD) % MOD) < 8 && $urandom_range(0, 1) == 1) wr_cnt = (wr_cnt + 1) % MOD;
      RDreq = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (FIFOempty !== (rd_cnt == vis2) || RDen !== (RDreq && rd_cnt != vis2) ||
          RDaddr !== AW'(rd_cnt % 8) || GrayRDaddr !== to_gray(rd_cnt) || RDerr !== m_err) begin
        miscompares++;
        $display("FAIL random%0d: empty=%b rden=%b rdaddr=%0d gray=%b err=%b required empty=%b rden=%b rdaddr=%0d gray=%b err=%b",
                 i, FIFOempty, RDen, RDaddr, GrayRDaddr, RDerr, rd_cnt == vis2, RDreq && rd_cnt != vis2,
                 rd_cnt % 8, to_gray(rd_cnt), m_err);
      end
`ifdef AFIFO_RD_LEVEL_EN
      vectors++;
      if (RDlevel !== (AW+1)'(m_lvl) || FIFOalmostEmpty !== m_ae) begin
        miscompares++;
        $display("FAIL random_level%0d: level=%0d ae=%b required level=%0d ae=%b", i, RDlevel, FIFOalmostEmpty, m_lvl, m_ae);
      end
`endif
      step();
    end
    RDreq = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RDreq       = 1'b0;
    model_reset();
    reset       = 1'b0;
    #12;
    test_reset();
    test_sync_latency();
    test_burst_drain();
    test_underflow();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
